io_handshake_bridge: RTL and testbench

Byte-wide I/O bridge between the processor's handshake port (bus_out/hs_out, bus_in/hs_in) and an external valid/ready peripheral. It buffers outgoing bytes produced by the OUT path (R_OUT register) in a TX FIFO, and incoming bytes destined for the RIN register in an RX FIFO. It answers the processor's four-phase handshake so the controller stalls only when the relevant FIFO is full (OUT) or empty (IN).

---
 rtl/io_handshake_bridge.sv | 127 ++++++++++++
 tb/tb_io_handshake_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_bridge.sv
// Byte-wide bridge between the processor's four-phase handshake port and an
// external valid/ready peripheral. Outgoing bytes queue in a TX FIFO,
// incoming bytes in an RX FIFO; the processor stalls only on TX full (OUT)
// or RX empty (IN).
module io_handshake_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          g_clk,
  input  logic          g_clr,
  input  logic [7:0]    cpu_bus_out,
  input  logic          cpu_hs_out,
  input  logic          cpu_rd,
  output logic [7:0]    cpu_bus_in,
  output logic          cpu_hs_in,
  input  logic [7:0]    ext_rx_data,
  input  logic          ext_rx_valid,
  output logic          ext_rx_ready,
  output logic [7:0]    ext_tx_data,
  output logic          ext_tx_valid,
  input  logic          ext_tx_ready,
  output logic [AW:0]   rx_count,
  output logic [AW:0]   tx_count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_ACK} state_t;
  state_t state;

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [AW:0]   rx_cnt, tx_cnt;
  logic          rx_push, rx_pop, tx_push, tx_pop;

  // Flow-control flags depend only on registered occupancy.
  always_comb begin
    ext_rx_ready = (rx_cnt != FULL);
    ext_tx_valid = (tx_cnt != '0);
    ext_tx_data  = ext_tx_valid ? tx_mem[tx_rp] : '0;
    rx_count     = rx_cnt;
    tx_count     = tx_cnt;
  end

  // Transfer strobes; the CPU side only acts from IDLE, so a held request
  // is serviced exactly once.
  always_comb begin
    rx_push = ext_rx_valid & ext_rx_ready;
    tx_pop  = ext_tx_valid & ext_tx_ready;
    rx_pop  = (state == S_IDLE) & cpu_hs_out &  cpu_rd & (rx_cnt != '0);
    tx_push = (state == S_IDLE) & cpu_hs_out & ~cpu_rd & (tx_cnt != FULL);
  end

  // FIFO storage writes (contents are not cleared by reset).
  always_ff @(posedge g_clk) begin
    if (rx_push) rx_mem[rx_wp] <= ext_rx_data;
    if (tx_push) tx_mem[tx_wp] <= cpu_bus_out;
  end

  // RX pointers and occupancy.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // TX pointers and occupancy.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // Handshake FSM with registered acknowledge and read-data latch.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state      <= S_IDLE;
      cpu_hs_in  <= 1'b0;
      cpu_bus_in <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_pop) begin
            cpu_bus_in <= rx_mem[rx_rp];
            cpu_hs_in  <= 1'b1;
            state      <= S_ACK;
          end else if (tx_push) begin
            cpu_hs_in  <= 1'b1;
            state      <= S_ACK;
          end
        end
        S_ACK: begin
          if (!cpu_hs_out) begin
            cpu_hs_in <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          cpu_hs_in <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_handshake_bridge.sv
// Randomized scoreboard bench for io_handshake_bridge: a queue-based model
// predicts FIFO contents and acknowledge timing; a negedge monitor compares.
module tb_io_handshake_bridge;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          g_clk = 1'b0;
  logic          g_clr = 1'b0;
  logic [7:0]    cpu_bus_out = '0;
  logic          cpu_hs_out = 1'b0;
  logic          cpu_rd = 1'b0;
  logic [7:0]    cpu_bus_in;
  logic          cpu_hs_in;
  logic [7:0]    ext_rx_data = '0;
  logic          ext_rx_valid = 1'b0;
  logic          ext_rx_ready;
  logic [7:0]    ext_tx_data;
  logic          ext_tx_valid;
  logic          ext_tx_ready = 1'b0;
  logic [AW:0]   rx_count;
  logic [AW:0]   tx_count;

  int checks = 0;
  int errors = 0;

  io_handshake_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .cpu_bus_out(cpu_bus_out), .cpu_hs_out(cpu_hs_out), .cpu_rd(cpu_rd),
    .cpu_bus_in(cpu_bus_in), .cpu_hs_in(cpu_hs_in),
    .ext_rx_data(ext_rx_data), .ext_rx_valid(ext_rx_valid), .ext_rx_ready(ext_rx_ready),
    .ext_tx_data(ext_tx_data), .ext_tx_valid(ext_tx_valid), .ext_tx_ready(ext_tx_ready),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] in_exp[$];
  logic [7:0] tx_exp[$];
  bit         m_ack = 1'b0;
  logic [7:0] m_bus = '0;
  int         m_rn, m_tn;
  bit         m_rx_push, m_tx_pop;

  always @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      rxq.delete(); txq.delete(); in_exp.delete(); tx_exp.delete();
      m_ack = 1'b0;
      m_bus = '0;
    end else begin
      m_rn = rxq.size();
      m_tn = txq.size();
      m_rx_push = ext_rx_valid && (m_rn < DEPTH);
      m_tx_pop  = ext_tx_ready && (m_tn > 0);
      if (m_tx_pop) void'(txq.pop_front());
      if (!m_ack) begin
        if (cpu_hs_out && cpu_rd && m_rn > 0) begin
          m_bus = rxq.pop_front();
          in_exp.push_back(m_bus);
          m_ack = 1'b1;
        end else if (cpu_hs_out && !cpu_rd && m_tn < DEPTH) begin
          txq.push_back(cpu_bus_out);
          tx_exp.push_back(cpu_bus_out);
          m_ack = 1'b1;
        end
      end else if (!cpu_hs_out) begin
        m_ack = 1'b0;
      end
      if (m_rx_push) rxq.push_back(ext_rx_data);
    end
  end

  // ---------------- monitor ----------------
  logic       hs_prev = 1'b0;
  logic [7:0] exp_b;

  always @(negedge g_clk) begin
    if (cpu_hs_in === 1'b1 && hs_prev !== 1'b1 && cpu_rd) begin
      if (in_exp.size() == 0) begin
        chk("in_ack_unexpected", 32'(cpu_bus_in), 32'hFFFF_FFFF);
      end else begin
        exp_b = in_exp.pop_front();
        chk("in_data", 32'(cpu_bus_in), 32'(exp_b));
      end
    end
    hs_prev = cpu_hs_in;
    chk("hs_in", 32'(cpu_hs_in), 32'(m_ack));
    chk("bus_in_hold", 32'(cpu_bus_in), 32'(m_bus));
    chk("rx_count", 32'(rx_count), 32'(rxq.size()));
    chk("tx_count", 32'(tx_count), 32'(txq.size()));
    chk("rx_ready", 32'(ext_rx_ready), 32'(rxq.size() < DEPTH));
    chk("tx_valid", 32'(ext_tx_valid), 32'(txq.size() > 0));
    if (txq.size() == 0) chk("tx_data_empty", 32'(ext_tx_data), 32'h0);
    if (ext_tx_valid === 1'b1 && ext_tx_ready) begin
      if (tx_exp.size() == 0) begin
        chk("tx_pop_unexpected", 32'(ext_tx_data), 32'hFFFF_FFFF);
      end else begin
        exp_b = tx_exp.pop_front();
        chk("tx_data", 32'(ext_tx_data), 32'(exp_b));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge g_clk);
    #2;
  endtask

  task automatic wait_hs(input logic v, input int lim);
    int n = 0;
    tick();
    while (cpu_hs_in !== v && n < lim) begin
      tick();
      n++;
    end
    chk("hs_wait_timeout", 32'(cpu_hs_in), 32'(v));
  endtask

  task automatic cpu_xfer(input logic rd, input logic [7:0] d);
    cpu_rd = rd;
    cpu_bus_out = d;
    cpu_hs_out = 1'b1;
    wait_hs(1'b1, 50);
    cpu_hs_out = 1'b0;
    wait_hs(1'b0, 50);
  endtask

  int held;

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      cpu_hs_out   = 1'($urandom);
      cpu_rd       = 1'($urandom);
      cpu_bus_out  = 8'($urandom);
      ext_rx_valid = 1'($urandom);
      ext_rx_data  = 8'($urandom);
      ext_tx_ready = 1'($urandom);
      tick();
    end
    chk("rst_hs_in", 32'(cpu_hs_in), 32'h0);
    chk("rst_tx_valid", 32'(ext_tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(ext_rx_ready), 32'h1);
    chk("rst_bus_in", 32'(cpu_bus_in), 32'h0);
    cpu_hs_out = 1'b0; ext_rx_valid = 1'b0; ext_tx_ready = 1'b0;
    tick();
    g_clr = 1'b1;
    tick();

    // OUT path with draining peripheral
    ext_tx_ready = 1'b1;
    cpu_xfer(1'b0, 8'hA5);
    cpu_xfer(1'b0, 8'h3C);
    repeat (3) tick();
    chk("out_drained", 32'(tx_count), 32'h0);

    // TX full stall
    ext_tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) cpu_xfer(1'b0, 8'($urandom));
    cpu_rd = 1'b0; cpu_bus_out = 8'h5A; cpu_hs_out = 1'b1;
    repeat (4) tick();
    chk("tx_full_stall", 32'(cpu_hs_in), 32'h0);
    ext_tx_ready = 1'b1;
    tick();
    ext_tx_ready = 1'b0;
    wait_hs(1'b1, 10);
    chk("tx_full_count", 32'(tx_count), 32'(DEPTH));
    cpu_hs_out = 1'b0;
    wait_hs(1'b0, 10);
    ext_tx_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    ext_tx_ready = 1'b0;

    // IN empty stall
    cpu_rd = 1'b1; cpu_hs_out = 1'b1;
    repeat (3) tick();
    chk("in_empty_stall", 32'(cpu_hs_in), 32'h0);
    ext_rx_valid = 1'b1; ext_rx_data = 8'h7E;
    tick();
    ext_rx_valid = 1'b0;
    chk("in_not_yet", 32'(cpu_hs_in), 32'h0);
    tick();
    chk("in_ack_n1", 32'(cpu_hs_in), 32'h1);
    chk("in_data_7e", 32'(cpu_bus_in), 32'h7E);
    chk("in_rx_empty", 32'(rx_count), 32'h0);
    cpu_hs_out = 1'b0;
    wait_hs(1'b0, 10);

    // Randomized concurrent traffic (RX wrap, simultaneous push/pop)
    held = 0;
    for (int c = 0; c < 600; c++) begin
      ext_rx_valid = ($urandom_range(0, 3) != 0);
      ext_rx_data  = 8'($urandom);
      ext_tx_ready = 1'($urandom);
      if (!cpu_hs_out) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_hs_out  = 1'b1;
          cpu_rd      = ($urandom_range(0, 9) < 6);
          cpu_bus_out = 8'($urandom);
          held = 0;
        end
      end else if (cpu_hs_in) begin
        held++;
        if (held > 1 && $urandom_range(0, 3) == 0) cpu_rd = ~cpu_rd;
        if ($urandom_range(0, 1) == 1) cpu_hs_out = 1'b0;
      end
      tick();
    end
    cpu_hs_out = 1'b0; ext_rx_valid = 1'b0;
    wait_hs(1'b0, 10);
    ext_tx_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    ext_tx_ready = 1'b0;
    for (int i = 0; i < 8 && rx_count != '0; i++) cpu_xfer(1'b1, 8'h00);

    // Reset mid-ACK with two entries in each FIFO
    cpu_xfer(1'b0, 8'h11);
    cpu_xfer(1'b0, 8'h22);
    ext_rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ext_rx_data = 8'(8'h40 + i);
      tick();
    end
    ext_rx_valid = 1'b0;
    cpu_rd = 1'b1; cpu_hs_out = 1'b1;
    wait_hs(1'b1, 10);
    chk("pre_rst_rx", 32'(rx_count), 32'h2);
    chk("pre_rst_tx", 32'(tx_count), 32'h2);
    g_clr = 1'b0;
    #1;
    chk("rst_async_hs", 32'(cpu_hs_in), 32'h0);
    chk("rst_async_rx", 32'(rx_count), 32'h0);
    chk("rst_async_tx", 32'(tx_count), 32'h0);
    cpu_rd = 1'b0; cpu_bus_out = 8'h99;
    tick();
    tick();
    g_clr = 1'b1;
    wait_hs(1'b1, 10);
    chk("post_rst_new_req", 32'(tx_count), 32'h1);
    chk("post_rst_tx_head", 32'(ext_tx_data), 32'h99);
    cpu_hs_out = 1'b0;
    wait_hs(1'b0, 10);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
